// File: rtl/rv32e_data_mem_if.sv
// CPU data-port bundle: byte address, store data and strobe out of the CPU, load data back.
// The CPU drives the master side and the data memory sits on the slave side.
interface rv32e_data_mem_if;
    logic [31:0] mem_addr_bus;
    logic [31:0] mem_write_data_bus;
    logic        mem_write_signal;
    logic [31:0] mem_read_data_bus;

    modport master (
        output mem_addr_bus,
        output mem_write_data_bus,
        output mem_write_signal,
        input  mem_read_data_bus
    );

    modport slave (
        input  mem_addr_bus,
        input  mem_write_data_bus,
        input  mem_write_signal,
        output mem_read_data_bus
    );
endinterface

// File: rtl/rv32e_data_mem.sv
// Purpose: rv32e data memory, word RAM plus a 16-byte MMIO window (GPIO, cycles, stores, status).
// Latency: reads are combinational from the address; writes commit on the strobed posedge.
// Backpressure: none, one access per cycle. RV32E_DMEM_CYCLE_COUNTER_EN enables the cycle counter.
module rv32e_data_mem #(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
    input  logic              clk,
    input  logic              reset,
    rv32e_data_mem_if.slave   bus,
    output logic [31:0]       gpio_out,
    output logic              bus_error
);
    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0]   mem_q [DEPTH_WORDS];
    logic [31:0]   gpio_q, gpio_d;
    logic          err_q, err_d;
    logic [31:0]   store_cnt_q, store_cnt_d;
    logic [31:0]   cycle_cnt;

    logic [31:0]   addr;
    logic          misaligned, ram_hit, mmio_hit;
    logic [1:0]    off;
    logic [AW-1:0] ram_idx;
    logic          ram_we, gpio_we, stat_we, err_set;

    assign addr       = bus.mem_addr_bus;
    assign misaligned = |addr[1:0];
    assign ram_hit    = ~|addr[31:AW+2];
    assign mmio_hit   = addr[31:4] == MMIO_BASE[31:4];
    assign off        = addr[3:2];
    assign ram_idx    = addr[AW+1:2];

    always_comb begin
        bus.mem_read_data_bus = '0;
        if (!misaligned) begin
            if (ram_hit) begin
                bus.mem_read_data_bus = mem_q[ram_idx];
            end else if (mmio_hit) begin
                case (off)
                    2'd0:    bus.mem_read_data_bus = gpio_q;
                    2'd1:    bus.mem_read_data_bus = cycle_cnt;
                    2'd2:    bus.mem_read_data_bus = store_cnt_q;
                    default: bus.mem_read_data_bus = {31'b0, err_q};
                endcase
            end
        end
    end

    // CYCLE and STORES writes fall through as silently ignored, not errors.
    always_comb begin
        ram_we      = bus.mem_write_signal && !misaligned && ram_hit;
        gpio_we     = bus.mem_write_signal && !misaligned && !ram_hit && mmio_hit && (off == 2'd0);
        stat_we     = bus.mem_write_signal && !misaligned && !ram_hit && mmio_hit && (off == 2'd3);
        err_set     = bus.mem_write_signal && (misaligned || (!ram_hit && !mmio_hit));
        gpio_d      = gpio_we ? bus.mem_write_data_bus : gpio_q;
        err_d       = err_set ? 1'b1 : (stat_we ? 1'b0 : err_q);
        store_cnt_d = store_cnt_q + {31'b0, ram_we | gpio_we | stat_we};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            gpio_q      <= '0;
            err_q       <= 1'b0;
            store_cnt_q <= '0;
        end else begin
            gpio_q      <= gpio_d;
            err_q       <= err_d;
            store_cnt_q <= store_cnt_d;
        end
    end

    // RAM contents survive reset; reset only blocks the write.
    always_ff @(posedge clk) begin
        if (reset && ram_we) begin
            mem_q[ram_idx] <= bus.mem_write_data_bus;
        end
    end

`ifdef RV32E_DMEM_CYCLE_COUNTER_EN
    logic [31:0] cycle_cnt_q;
    always_ff @(posedge clk) begin
        if (!reset) begin
            cycle_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_q + 32'd1;
        end
    end
    assign cycle_cnt = cycle_cnt_q;
`else
    assign cycle_cnt = '0;
`endif

    assign gpio_out  = gpio_q;
    assign bus_error = err_q;
endmodule

// File: tb/tb_rv32e_data_mem.sv
// Bench for rv32e_data_mem: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against an address-range model of the memory map.
module tb_rv32e_data_mem;
    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] gpio_out;
    logic        bus_error;

    rv32e_data_mem_if bus ();

    rv32e_data_mem #(.DEPTH_WORDS(DEPTH), .MMIO_BASE(BASE)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .gpio_out  (gpio_out),
        .bus_error (bus_error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model of the memory map.
    logic [31:0] m_mem [DEPTH];
    bit          m_vld [DEPTH];
    logic [31:0] m_gpio, m_stores, m_cycles;
    logic        m_err;
    bit          started = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_read(input logic [31:0] a, output logic [31:0] e, output bit known);
        e = '0;
        known = 1;
        if (a % 4 != 0) begin
            e = '0;
        end else if (a < DEPTH * 4) begin
            e = m_mem[a / 4];
            known = m_vld[a / 4];
        end else if (a >= BASE && a - BASE < 16) begin
            case ((a - BASE) / 4)
                0: e = m_gpio;
`ifdef RV32E_DMEM_CYCLE_COUNTER_EN
                1: e = m_cycles;
`else
                1: e = 32'd0;
`endif
                2: e = m_stores;
                default: e = {31'b0, m_err};
            endcase
        end
    endfunction

    always @(posedge clk) begin
        logic [31:0] a;
        a = bus.mem_addr_bus;
        if (!reset) begin
            started  <= 1;
            m_gpio   <= '0;
            m_err    <= 1'b0;
            m_stores <= '0;
            m_cycles <= '0;
        end else if (started) begin
            m_cycles <= m_cycles + 1;
            if (bus.mem_write_signal) begin
                if (a % 4 != 0) begin
                    m_err <= 1'b1;
                end else if (a < DEPTH * 4) begin
                    m_mem[a / 4] <= bus.mem_write_data_bus;
                    m_vld[a / 4] <= 1;
                    m_stores     <= m_stores + 1;
                end else if (a >= BASE && a - BASE < 16) begin
                    if (a - BASE == 0) begin
                        m_gpio   <= bus.mem_write_data_bus;
                        m_stores <= m_stores + 1;
                    end else if (a - BASE == 12) begin
                        m_err    <= 1'b0;
                        m_stores <= m_stores + 1;
                    end
                end else begin
                    m_err <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [31:0] e;
        bit          k;
        if (started) begin
            chk("gpio_out", gpio_out, m_gpio);
            chk("bus_error", {31'b0, bus_error}, {31'b0, m_err});
            model_read(bus.mem_addr_bus, e, k);
            if (k) chk("read_data", bus.mem_read_data_bus, e);
        end
    end

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r);
        @(posedge clk);
        #1;
        bus.mem_addr_bus       = a;
        bus.mem_write_data_bus = d;
        bus.mem_write_signal   = w;
        reset                  = r;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    logic [31:0] ra;

    initial begin
        bus.mem_addr_bus       = BASE + 32'h8;
        bus.mem_write_data_bus = '0;
        bus.mem_write_signal   = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_vld[i] = 0;

        // Reset state
        drive(BASE + 32'h8, 0, 0, 0);
        drive(BASE + 32'h8, 0, 0, 0);
        settle();
        chk("rst_gpio", gpio_out, 32'h0);
        chk("rst_err", {31'b0, bus_error}, 32'h0);
        chk("rst_stores", bus.mem_read_data_bus, 32'h0);
        drive(BASE + 32'hC, 0, 0, 0);
        settle();
        chk("rst_status", bus.mem_read_data_bus, 32'h0);

        // RAM write then same-cycle combinational read
        drive(32'h10, 32'hDEAD_BEEF, 1, 1);
        drive(32'h10, 0, 0, 1);
        settle();
        chk("ram_rd", bus.mem_read_data_bus, 32'hDEAD_BEEF);
        drive(BASE + 32'h8, 0, 0, 1);
        settle();
        chk("stores_1", bus.mem_read_data_bus, 32'd1);

        // GPIO
        drive(BASE, 32'h0000_00A5, 1, 1);
        drive(BASE, 0, 0, 1);
        settle();
        chk("gpio_val", gpio_out, 32'hA5);
        chk("gpio_rd", bus.mem_read_data_bus, 32'hA5);
        drive(BASE + 32'h8, 0, 0, 1);
        settle();
        chk("stores_2", bus.mem_read_data_bus, 32'd2);

        // Misaligned and unmapped stores set the sticky error
        drive(32'h0000_0402, 32'h1111, 1, 1);
        drive(32'h0000_1000, 32'h2222, 1, 1);
        drive(32'h10, 0, 0, 1);
        settle();
        chk("err_set", {31'b0, bus_error}, 32'h1);
        chk("ram_kept", bus.mem_read_data_bus, 32'hDEAD_BEEF);
        drive(32'h0000_0400, 0, 0, 1);
        settle();
        chk("unmapped_rd", bus.mem_read_data_bus, 32'h0);
        drive(BASE + 32'h8, 0, 0, 1);
        settle();
        chk("stores_err", bus.mem_read_data_bus, 32'd2);
        drive(BASE + 32'hC, 32'hFFFF_FFFF, 1, 1);
        drive(BASE + 32'hC, 0, 0, 1);
        settle();
        chk("err_clr", {31'b0, bus_error}, 32'h0);
        chk("status_rd", bus.mem_read_data_bus, 32'h0);
        drive(BASE + 32'h8, 0, 0, 1);
        settle();
        chk("stores_3", bus.mem_read_data_bus, 32'd3);

        // Cycle counter after a fresh reset
        drive(BASE + 32'h4, 0, 0, 0);
        for (int i = 0; i < 11; i++) drive(BASE + 32'h4, 0, 0, 1);
        settle();
`ifdef RV32E_DMEM_CYCLE_COUNTER_EN
        chk("cycle_10", bus.mem_read_data_bus, 32'd10);
`else
        chk("cycle_off", bus.mem_read_data_bus, 32'd0);
`endif
        drive(BASE + 32'h4, 32'h1234, 1, 1);
        drive(BASE + 32'h8, 0, 0, 1);
        settle();
        chk("cycle_wr_err", {31'b0, bus_error}, 32'h0);
        chk("cycle_wr_nocount", bus.mem_read_data_bus, 32'd0);

        // Reset wins over a simultaneous store
        drive(32'h20, 32'hCAFE_F00D, 1, 1);
        drive(32'h20, 32'h55, 1, 0);
        drive(32'h20, 0, 0, 1);
        settle();
        chk("rst_wr_ram", bus.mem_read_data_bus, 32'hCAFE_F00D);
        drive(BASE + 32'h8, 0, 0, 1);
        settle();
        chk("rst_wr_stores", bus.mem_read_data_bus, 32'd0);

        // Randomized traffic, checked by the per-cycle compare process
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 5))
                0, 1: ra = 32'($urandom_range(0, 15)) * 4;
                2:    ra = BASE + 32'($urandom_range(0, 3)) * 4;
                3: begin
                    ra = $urandom;
                    if (ra[1:0] == 2'b00) ra[0] = 1'b1;
                end
                4:    ra = 32'h0000_1000 + 32'($urandom_range(0, 255)) * 4;
                default: ra = $urandom;
            endcase
            drive(ra, $urandom, ($urandom_range(0, 9) < 3), ($urandom_range(0, 63) != 0));
        end
        drive(0, 0, 0, 1);
        settle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
